// File: rtl/pmem_responder.sv
// Cache-line physical-memory responder: one 128-bit line read/write at a time, programmable latency.
// Optional protocol checker enabled by defining PMEM_PROTOCOL_CHECK_EN (adds protocol_err output).
module pmem_responder #(
  parameter int ADDR_W        = 16,
  parameter int LINE_W        = 128,
  parameter int DEPTH_LINES   = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [LINE_W-1:0] pmem_rdata,
`ifdef PMEM_PROTOCOL_CHECK_EN
  output logic              protocol_err,
`endif
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

  logic [1:0]        state;
  logic [7:0]        cnt;
  logic              op_wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] mem [DEPTH_LINES];

  logic              accept;
  logic [7:0]        load_val;
  logic              enter_resp;
  logic              eff_wr;
  logic [IDX_W-1:0]  eff_idx;
  logic [LINE_W-1:0] eff_wdata;
  logic [IDX_W-1:0]  addr_idx;

  assign addr_idx = pmem_address[4 +: IDX_W];
  assign accept   = (state == ST_IDLE) && (pmem_write || pmem_read);
  assign load_val = pmem_write ? WR_LOAD : RD_LOAD;

  // A latency-1 transaction completes on its accept edge, so the array access
  // must come straight from the request inputs rather than the capture registers.
  always_comb begin
    eff_wr     = op_wr_q;
    eff_idx    = idx_q;
    eff_wdata  = wdata_q;
    enter_resp = 1'b0;
    if (state == ST_IDLE) begin
      eff_wr     = pmem_write;
      eff_idx    = addr_idx;
      eff_wdata  = pmem_wdata;
      enter_resp = accept && (load_val == 8'd0);
    end else if (state == ST_WAIT) begin
      enter_resp = (cnt == 8'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt   <= load_val;
            state <= (load_val == 8'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_q <= pmem_write;
      idx_q   <= addr_idx;
      wdata_q <= pmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && eff_wr) mem[eff_idx] <= eff_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (enter_resp && !eff_wr) begin
      rdata_q <= mem[eff_idx];
    end
  end

  assign pmem_resp  = (state == ST_RESP);
  assign busy       = (state == ST_WAIT);
  assign pmem_rdata = rdata_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] addr_q;
  logic              req_held;
  logic              violation;

  always_ff @(posedge clk) begin
    if (accept) addr_q <= pmem_address;
  end

  // While waiting, the original request must stay exactly as accepted.
  assign req_held  = op_wr_q ? (pmem_write && !pmem_read) : (pmem_read && !pmem_write);
  assign violation = (pmem_read && pmem_write) ||
                     ((state == ST_WAIT) && (!req_held || (pmem_address != addr_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         protocol_err <= 1'b0;
    else if (violation) protocol_err <= 1'b1;
  end
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[3:0], pmem_address[ADDR_W-1:4+IDX_W]};

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized bench for pmem_responder: two instances (latency 4/4 and 1/2) against a line-array model.
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pr [2];
  logic         pw [2];
  logic [15:0]  pa [2];
  logic [127:0] pd [2];
  logic         resp [2];
  logic         busy [2];
  logic [127:0] rdata [2];
`ifdef PMEM_PROTOCOL_CHECK_EN
  logic         perr [2];
`endif

  int           total = 0;
  int           bad = 0;
  int           lat_rd [2] = '{4, 1};
  int           lat_wr [2] = '{4, 2};
  logic [127:0] mem_m [2][256];
  logic [127:0] last_rd [2];

  always #5 clk = ~clk;

  pmem_responder #(.READ_LATENCY(4), .WRITE_LATENCY(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pr[0]), .pmem_write(pw[0]), .pmem_address(pa[0]), .pmem_wdata(pd[0]),
    .pmem_resp(resp[0]), .pmem_rdata(rdata[0]),
`ifdef PMEM_PROTOCOL_CHECK_EN
    .protocol_err(perr[0]),
`endif
    .busy(busy[0])
  );

  pmem_responder #(.READ_LATENCY(1), .WRITE_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pr[1]), .pmem_write(pw[1]), .pmem_address(pa[1]), .pmem_wdata(pd[1]),
    .pmem_resp(resp[1]), .pmem_rdata(rdata[1]),
`ifdef PMEM_PROTOCOL_CHECK_EN
    .protocol_err(perr[1]),
`endif
    .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete transaction: drive in cycle T, expect resp in cycle T+latency.
  task automatic txn(input int d, input bit w, input logic [15:0] a,
                     input logic [127:0] data, input bit both);
    int  k;
    int  lat;
    int  bcnt;
    bit  got;
    int  idx;
    idx   = int'(a[11:4]);
    lat   = (w || both) ? lat_wr[d] : lat_rd[d];
    pw[d] = w || both;
    pr[d] = !w || both;
    pa[d] = a;
    pd[d] = data;
    k = 0; bcnt = 0; got = 0;
    while (!got && k < 300) begin
      @(negedge clk);
      k++;
      if (resp[d]) got = 1;
      else if (busy[d]) bcnt++;
    end
    pw[d] = 1'b0;
    pr[d] = 1'b0;
    chk("resp_seen", got, 1'b1);
    chk("latency", k, lat);
    chk("busy_cycles", bcnt, lat - 1);
    chk("busy_in_resp", busy[d], 1'b0);
    if (w || both) begin
      mem_m[d][idx] = data;
      chk("rdata_kept_on_write", rdata[d], last_rd[d]);
    end else begin
      chk("rdata", rdata[d], mem_m[d][idx]);
      last_rd[d] = mem_m[d][idx];
    end
    @(negedge clk);
    chk("resp_one_cycle", resp[d], 1'b0);
    chk("rdata_held", rdata[d], last_rd[d]);
  endtask

  initial begin
    int           n;
    bit           got;
    logic [127:0] r1;
    for (int d = 0; d < 2; d++) begin
      pr[d] = 0; pw[d] = 0; pa[d] = '0; pd[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_resp", resp[d], 1'b0);
      chk("reset_busy", busy[d], 1'b0);
      chk("reset_rdata", rdata[d], '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
      chk("reset_perr", perr[d], 1'b0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Fill every line so the model knows the whole array.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        txn(d, 1'b1, 16'(i << 4), rand_line(), 1'b0);

    // Write then read the same line through different offsets.
    txn(0, 1'b1, 16'h0120, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    txn(0, 1'b0, 16'h0128, '0, 1'b0);
    chk("wr_rd_value", rdata[0], 128'h0123456789ABCDEF_FEDCBA9876543210);

    // Latency-1 reads on the second instance.
    txn(1, 1'b1, 16'h0450, 128'hCAFE, 1'b0);
    txn(1, 1'b0, 16'h0450, '0, 1'b0);
    chk("lat1_value", rdata[1], 128'hCAFE);

    // Aliasing and ignored offset bits.
    txn(0, 1'b1, 16'h1010, {32{4'h5}}, 1'b0);
    txn(0, 1'b0, 16'h0010, '0, 1'b0);
    chk("alias_value", rdata[0], {32{4'h5}});
    txn(0, 1'b0, 16'h101F, '0, 1'b0);
    chk("offset_value", rdata[0], {32{4'h5}});

    // Simultaneous read and write is a write.
    txn(0, 1'b0, 16'h0040, {32{4'hA}}, 1'b1);
    txn(0, 1'b0, 16'h0040, '0, 1'b0);
    chk("both_is_write", rdata[0], {32{4'hA}});
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("perr_set", perr[0], 1'b1);
    txn(0, 1'b0, 16'h0050, '0, 1'b0);
    chk("perr_sticky", perr[0], 1'b1);
`endif

    // Back-to-back reads from a held request.
    pr[0] = 1'b1; pa[0] = 16'h0300;
    got = 0; n = 0;
    while (!got && n < 300) begin @(negedge clk); n++; if (resp[0]) got = 1; end
    chk("b2b_first_resp", got, 1'b1);
    r1 = rdata[0];
    got = 0; n = 0;
    while (!got && n < 300) begin
      @(negedge clk); n++;
      if (n == 2) pr[0] = 1'b0;
      if (resp[0]) got = 1;
    end
    pr[0] = 1'b0;
    chk("b2b_second_resp", got, 1'b1);
    chk("b2b_spacing", n, lat_rd[0] + 1);
    chk("b2b_same_data", rdata[0], r1);
    chk("b2b_value", rdata[0], mem_m[0][8'h30]);
    last_rd[0] = mem_m[0][8'h30];
    @(negedge clk);

    // Reset during a pending write discards it.
    pw[0] = 1'b1; pa[0] = 16'h0200; pd[0] = rand_line();
    @(negedge clk);
    chk("rst_mid_busy", busy[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    pw[0] = 1'b0;
    chk("rst_mid_resp", resp[0], 1'b0);
    chk("rst_mid_busy0", busy[0], 1'b0);
    chk("rst_mid_rdata", rdata[0], '0);
    chk("rst_other_rdata", rdata[1], '0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_resp", resp[0], 1'b0);
    end
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    chk("rst_release_rdata", rdata[0], '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("perr_cleared", perr[0], 1'b0);
`endif
    txn(0, 1'b0, 16'h0200, '0, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 60; i++)
      txn(0, 1'($urandom_range(0, 1)), 16'($urandom), rand_line(), 1'b0);
    for (int i = 0; i < 40; i++)
      txn(1, 1'($urandom_range(0, 1)), 16'($urandom), rand_line(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory side of the cache-line pmem interface that the i/d caches and the arbiter drive.
- Accepts one 128-bit line read or write at a time, waits a programmable latency, then pulses pmem_resp for one cycle.
- Synthesizable line-store plus handshake FSM. Used as the memory model in system benches and as an on-chip backing store.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word).
- LINE_W, 128, line width in bits (lc3b_c_block).
- DEPTH_LINES, 256, number of lines stored; power of 2, 2..4096.
- READ_LATENCY, 4, cycles from accept to resp for reads; range 1..255.
- WRITE_LATENCY, 4, cycles from accept to resp for writes; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pmem_read  in  1  line read request; held until resp.
- pmem_write  in  1  line write request; held until resp.
- pmem_address  in  ADDR_W  byte address; bits [3:0] ignored.
- pmem_wdata  in  LINE_W  write line data.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  LINE_W  read line data; valid in the resp cycle, held until the next read resp.
- busy  out  1  high while a transaction is accepted and not yet responded.

Behaviour:
- Reset (async assert, sync release): state IDLE, pmem_resp=0, pmem_rdata=0, busy=0, counter=0. Line array contents are not reset.
- Line index = pmem_address[4 +: log2(DEPTH_LINES)]. Higher address bits are ignored, so addresses alias modulo DEPTH_LINES*16 bytes.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If pmem_write=1, accept a write. pmem_write has priority over pmem_read.
  - Else if pmem_read=1, accept a read.
  - On accept, capture op, index and wdata into internal registers. Load counter with LATENCY-1. Go to WAIT, or straight to RESP if LATENCY=1.
- WAIT: decrement counter each cycle. When counter==0, go to RESP. busy=1.
- Transition into RESP (same edge):
  - Read: pmem_rdata <= array[idx].
  - Write: array[idx] <= captured wdata.
- RESP: pmem_resp=1 for exactly one cycle, busy=0, next state IDLE.
- Latency: request first seen in IDLE in cycle T gives pmem_resp high in cycle T+LATENCY.
- Back-to-back: a request still or newly asserted in the cycle after RESP is accepted as a new transaction. The requester must drop read/write in the cycle after resp to avoid a repeat.
- Inputs are ignored in WAIT and RESP. Address, data or op changes after accept have no effect.
- Read-after-write to the same line returns the written data; the array is updated before the read can be accepted.
- Reset mid-transaction: return to IDLE immediately and discard the pending op. The array is unchanged unless the write edge already occurred. No resp is produced.
- pmem_rdata is unchanged by writes and by reset release.

Optional Feature:
- Macro PMEM_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output port protocol_err (1 bit), reset 0, sticky until rst_n.
  - Sets on: pmem_read and pmem_write both high in any cycle; or the request drops, or the address/op changes, while in WAIT before resp.
  - Behaviour of the transaction itself is unchanged.
- Undefined: port and logic absent; no checking.

Test Plan:
- Write then read, READ/WRITE_LATENCY=4. Write addr 0x0120, data 0x0123456789ABCDEF_FEDCBA9876543210: resp 4 cycles after request. Then read 0x0128: resp after 4 cycles, rdata = that line; busy high exactly 3 cycles each.
- Latency 1: READ_LATENCY=1. Read asserted cycle T: resp and valid rdata in cycle T+1; busy never high.
- Simultaneous read+write at 0x0040, wdata 0xAA..AA: treated as a write; a subsequent read returns 0xAA..AA. With PMEM_PROTOCOL_CHECK_EN, protocol_err=1 and stays 1.
- Aliasing, DEPTH_LINES=256: write 0x1010 with 0x55..55, then read 0x0010 returns 0x55..55. Offset bits: read 0x101F returns the same line.
- Reset mid-write: write 0x0200 accepted, rst_n low during WAIT. No resp; resp=0, rdata=0, busy=0. After release, read 0x0200 returns the prior contents.
- Back-to-back: hold read 0x0300 for 2 cycles after resp. Two resps, separated by READ_LATENCY+1 cycles, identical rdata.
